// File: rtl/alu_operand_loader.sv
// Input stage for the 4-bit ALU: debounces the enter button and loads operand A, operand B
// and the opcode from the slide switches on successive presses, then holds them for the ALU.
module alu_operand_loader #(
    parameter int WIDTH           = 4,
    parameter int OPW             = 3,
    parameter int DEBOUNCE_CYCLES = 100000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] sw,
    input  logic             btn,
    input  logic             clr,
    output logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] b,
    output logic [OPW-1:0]   op,
    output logic             op_valid,
    output logic [1:0]       state
);

    // state | meaning
    // LOAD_A  | waiting for the press that captures operand A
    // LOAD_B  | waiting for the press that captures operand B
    // LOAD_OP | waiting for the press that captures the opcode
    // SHOW    | all three loaded; next press restarts at LOAD_A
    typedef enum logic [1:0] {
        LOAD_A  = 2'b00,
        LOAD_B  = 2'b01,
        LOAD_OP = 2'b10,
        SHOW    = 2'b11
    } state_t;

    localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [1:0]       sync;
    logic             btn_s;
    logic             deb;
    logic             deb_q;
    logic [CW-1:0]    cnt;
    logic             press;

    state_t           state_q;
    state_t           state_d;
    logic [WIDTH-1:0] a_d;
    logic [WIDTH-1:0] b_d;
    logic [OPW-1:0]   op_d;
    logic             valid_d;

    assign btn_s = sync[1];
    assign press = deb & ~deb_q;

    // Debounce: deb follows btn_s only after it has differed for DEBOUNCE_CYCLES cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync  <= '0;
            deb   <= 1'b0;
            deb_q <= 1'b0;
            cnt   <= '0;
        end else begin
            sync  <= {sync[0], btn};
            deb_q <= deb;
            if (btn_s == deb) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                deb <= ~deb;
                cnt <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= LOAD_A;
            a        <= '0;
            b        <= '0;
            op       <= '0;
            op_valid <= 1'b0;
        end else begin
            state_q  <= state_d;
            a        <= a_d;
            b        <= b_d;
            op       <= op_d;
            op_valid <= valid_d;
        end
    end

    always_comb begin
        state_d = state_q;
        a_d     = a;
        b_d     = b;
        op_d    = op;
        valid_d = 1'b0;
        // clr wins over a coincident press, which is simply dropped.
        if (clr) begin
            state_d = LOAD_A;
            a_d     = '0;
            b_d     = '0;
            op_d    = '0;
        end else if (press) begin
            unique case (state_q)
                LOAD_A: begin
                    a_d     = sw;
                    state_d = LOAD_B;
                end
                LOAD_B: begin
                    b_d     = sw;
                    state_d = LOAD_OP;
                end
                LOAD_OP: begin
                    op_d    = sw[OPW-1:0];
                    valid_d = 1'b1;
                    state_d = SHOW;
                end
                SHOW: begin
                    state_d = LOAD_A;
                end
                default: state_d = LOAD_A;
            endcase
        end
    end

    assign state = state_q;

endmodule

// File: tb/tb_alu_operand_loader.sv
// Bench for alu_operand_loader with a short debounce window: table-driven press sequence
// checked through an expected-result queue, plus bounce, hold, clr and reset corner cases.
module tb_alu_operand_loader;

    logic       clk;
    logic       rst_n;
    logic [3:0] sw;
    logic       btn;
    logic       clr;
    logic [3:0] dut_a;
    logic [3:0] dut_b;
    logic [2:0] dut_op;
    logic       dut_valid;
    logic [1:0] dut_state;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic [2:0] op;
        logic [1:0] st;
        logic       v;
    } exp_t;

    typedef struct {
        logic [3:0] sw;
        logic [3:0] ea;
        logic [3:0] eb;
        logic [2:0] eop;
        logic [1:0] est;
        logic       ev;
    } vec_t;

    exp_t exp_q[$];
    vec_t vecs[8];

    alu_operand_loader #(
        .WIDTH(4),
        .OPW(3),
        .DEBOUNCE_CYCLES(4)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .sw(sw),
        .btn(btn),
        .clr(clr),
        .a(dut_a),
        .b(dut_b),
        .op(dut_op),
        .op_valid(dut_valid),
        .state(dut_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_outputs(input string tag, input exp_t e);
        chk({tag, ".a"}, 32'(dut_a), 32'(e.a));
        chk({tag, ".b"}, 32'(dut_b), 32'(e.b));
        chk({tag, ".op"}, 32'(dut_op), 32'(e.op));
        chk({tag, ".state"}, 32'(dut_state), 32'(e.st));
        chk({tag, ".op_valid"}, 32'(dut_valid), 32'(e.v));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic exp_t mk(input logic [3:0] ea, input logic [3:0] eb,
                                input logic [2:0] eop, input logic [1:0] est, input logic ev);
        exp_t e;
        e.a = ea; e.b = eb; e.op = eop; e.st = est; e.v = ev;
        return e;
    endfunction

    // Hold btn high for `hold` cycles; the single expected state change is popped and compared.
    task automatic do_press(input string tag, input logic [3:0] swv, input int hold, input exp_t e);
        logic [1:0] prev;
        int         lat;
        int         changes;
        exp_t       got_exp;
        exp_t       after;
        sw = swv;
        exp_q.push_back(e);
        prev    = dut_state;
        lat     = -1;
        changes = 0;
        btn     = 1'b1;
        for (int n = 1; n <= hold; n++) begin
            tick();
            if (dut_state != prev) begin
                changes++;
                prev = dut_state;
                if (lat < 0) begin
                    lat = n;
                    if (exp_q.size() == 0) begin
                        chk({tag, ".queue_empty"}, 32'd0, 32'd1);
                    end else begin
                        got_exp = exp_q.pop_front();
                        chk_outputs(tag, got_exp);
                    end
                end
            end else if (lat > 0 && n == lat + 1) begin
                chk({tag, ".valid_after"}, 32'(dut_valid), 32'd0);
            end
        end
        if (lat < 0) begin
            chk({tag, ".timeout"}, 32'd0, 32'd1);
            void'(exp_q.pop_front());
        end
        chk({tag, ".latency"}, 32'(lat), 32'd7);
        chk({tag, ".changes"}, 32'(changes), 32'd1);
        btn   = 1'b0;
        after = mk(dut_a, dut_b, dut_op, dut_state, 1'b0);
        for (int n = 0; n < 10; n++) begin
            sw = 4'($urandom_range(0, 15));
            tick();
        end
        chk_outputs({tag, ".release"}, mk(e.a, e.b, e.op, e.st, 1'b0));
        chk({tag, ".sw_ignored"}, 32'(dut_a), 32'(after.a));
    endtask

    initial begin
        vecs[0] = '{4'h5, 4'h5, 4'h0, 3'h0, 2'b01, 1'b0};
        vecs[1] = '{4'hA, 4'h5, 4'hA, 3'h0, 2'b10, 1'b0};
        vecs[2] = '{4'h6, 4'h5, 4'hA, 3'h6, 2'b11, 1'b1};
        vecs[3] = '{4'hF, 4'h5, 4'hA, 3'h6, 2'b00, 1'b0};
        vecs[4] = '{4'h3, 4'h3, 4'hA, 3'h6, 2'b01, 1'b0};
        vecs[5] = '{4'hC, 4'h3, 4'hC, 3'h6, 2'b10, 1'b0};
        vecs[6] = '{4'h9, 4'h3, 4'hC, 3'h1, 2'b11, 1'b1};
        vecs[7] = '{4'h0, 4'h3, 4'hC, 3'h1, 2'b00, 1'b0};

        rst_n = 1'b0;
        btn   = 1'b0;
        clr   = 1'b0;
        sw    = 4'h0;
        tick();
        tick();
        chk_outputs("reset", mk(4'h0, 4'h0, 3'h0, 2'b00, 1'b0));
        rst_n = 1'b1;
        for (int n = 0; n < 20; n++) begin
            sw = 4'($urandom_range(0, 15));
            tick();
            if (dut_state != 2'b00 || dut_valid) chk("idle.quiet", 32'(dut_state), 32'd0);
        end
        chk_outputs("idle", mk(4'h0, 4'h0, 3'h0, 2'b00, 1'b0));

        for (int i = 0; i < 8; i++) begin
            do_press($sformatf("vec%0d", i), vecs[i].sw, 12,
                     mk(vecs[i].ea, vecs[i].eb, vecs[i].eop, vecs[i].est, vecs[i].ev));
        end

        // Bounce: pulses of 1-3 cycles never survive the 4-cycle window.
        begin
            int el;
            int moved;
            el    = 0;
            moved = 0;
            sw    = 4'h7;
            while (el < 30) begin
                btn = 1'b1;
                for (int k = int'($urandom_range(1, 3)); k > 0; k--) begin
                    tick(); el++;
                    if (dut_state != 2'b00) moved++;
                end
                btn = 1'b0;
                for (int k = int'($urandom_range(1, 3)); k > 0; k--) begin
                    tick(); el++;
                    if (dut_state != 2'b00) moved++;
                end
            end
            chk("bounce.no_press", 32'(moved), 32'd0);
        end
        do_press("bounce", 4'h7, 10, mk(4'h7, 4'hC, 3'h1, 2'b01, 1'b0));

        do_press("hold_b", 4'hB, 50, mk(4'h7, 4'hB, 3'h1, 2'b10, 1'b0));
        do_press("load_op", 4'h2, 12, mk(4'h7, 4'hB, 3'h2, 2'b11, 1'b1));
        do_press("wrap", 4'hE, 12, mk(4'h7, 4'hB, 3'h2, 2'b00, 1'b0));

        // clr lands on the press cycle while in LOAD_OP.
        do_press("clr_a", 4'h1, 12, mk(4'h1, 4'hB, 3'h2, 2'b01, 1'b0));
        do_press("clr_b", 4'h4, 12, mk(4'h1, 4'h4, 3'h2, 2'b10, 1'b0));
        begin
            int bad;
            bad = 0;
            sw  = 4'h5;
            btn = 1'b1;
            for (int n = 0; n < 6; n++) tick();
            chk("clr.pre_state", 32'(dut_state), 32'd2);
            clr = 1'b1;
            tick();
            clr = 1'b0;
            chk_outputs("clr", mk(4'h0, 4'h0, 3'h0, 2'b00, 1'b0));
            for (int n = 0; n < 10; n++) begin
                tick();
                if (dut_valid || dut_state != 2'b00) bad++;
            end
            chk("clr.stays", 32'(bad), 32'd0);
            btn = 1'b0;
            for (int n = 0; n < 10; n++) tick();
        end

        // Async reset while btn is held in LOAD_OP; the held button then loads a.
        do_press("rst_a", 4'h8, 12, mk(4'h8, 4'h0, 3'h0, 2'b01, 1'b0));
        do_press("rst_b", 4'hD, 12, mk(4'h8, 4'hD, 3'h0, 2'b10, 1'b0));
        begin
            int lat;
            lat = -1;
            sw  = 4'h3;
            btn = 1'b1;
            for (int n = 0; n < 3; n++) tick();
            rst_n = 1'b0;
            #2;
            chk_outputs("midrst", mk(4'h0, 4'h0, 3'h0, 2'b00, 1'b0));
            tick();
            tick();
            rst_n = 1'b1;
            exp_q.push_back(mk(4'h3, 4'h0, 3'h0, 2'b01, 1'b0));
            for (int n = 1; n <= 15; n++) begin
                tick();
                if (lat < 0 && dut_state != 2'b00) begin
                    lat = n;
                    chk_outputs("midrst.press", exp_q.pop_front());
                end
            end
            chk("midrst.latency", 32'(lat), 32'd7);
            chk("midrst.state_held", 32'(dut_state), 32'd1);
            btn = 1'b0;
            for (int n = 0; n < 10; n++) tick();
        end

        chk("scoreboard.drained", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
